// File: rtl/pe_array_drain.sv
// pe_array_drain: ping-pong result drain for the 2x16 PE array.
// Captures a full result tile on result_valid (optional ReLU), buffers up to
// two tiles and streams them out one row per valid/ready beat.
module pe_array_drain #(
    parameter int unsigned COL = 16,
    parameter int unsigned ROW = 2,
    parameter int unsigned DW  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           result_valid,
    input  logic [ROW-1:0][COL-1:0][DW-1:0] result_in,
    input  logic                           relu_en,
    output logic [COL*DW-1:0]              out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_row,
    output logic                           out_last,
    output logic                           busy,
    output logic                           full,
    output logic                           overflow,
    output logic [15:0]                    tile_cnt
);

    localparam int unsigned RW = COL * DW;

    // Ping-pong storage and pointers
    logic [1:0][ROW-1:0][RW-1:0] bank;
    logic [1:0][ROW-1:0][RW-1:0] bank_nxt;
    logic [1:0]                  bank_full;
    logic [1:0]                  bank_full_nxt;
    logic                        wr_ptr;
    logic                        wr_ptr_nxt;
    logic                        rd_ptr;
    logic                        rd_ptr_nxt;
    logic                        row_ptr;
    logic                        row_ptr_nxt;
    logic                        overflow_nxt;
    logic [15:0]                 tile_cnt_nxt;

    // Capture-side and handshake decode
    logic [ROW-1:0][RW-1:0]      cap_tile;
    logic                        hs;
    logic                        last_hs;
    logic                        free_same;
    logic                        cap;
    logic                        drop;

    // Repack the incoming tile into row words, zeroing negatives when ReLU is on
    always_comb begin
        cap_tile = '0;
        for (int unsigned r = 0; r < ROW; r++) begin
            for (int unsigned c = 0; c < COL; c++) begin
                if (relu_en && result_in[r][c][DW-1]) begin
                    cap_tile[r][c*DW +: DW] = '0;
                end else begin
                    cap_tile[r][c*DW +: DW] = result_in[r][c];
                end
            end
        end
    end

    // Handshake and capture/drop decisions; a bank freed this cycle may be refilled
    always_comb begin
        hs        = out_valid & out_ready;
        last_hs   = hs & out_last;
        free_same = last_hs & (rd_ptr == wr_ptr);
        cap       = result_valid & (~bank_full[wr_ptr] | free_same);
        drop      = result_valid & ~cap;
    end

    // Next-state for storage, pointers and counters; clr overrides capture and drain
    always_comb begin
        bank_nxt      = bank;
        bank_full_nxt = bank_full;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        row_ptr_nxt   = row_ptr;
        overflow_nxt  = overflow;
        tile_cnt_nxt  = tile_cnt;

        if (clr) begin
            bank_full_nxt = '0;
            wr_ptr_nxt    = 1'b0;
            rd_ptr_nxt    = 1'b0;
            row_ptr_nxt   = 1'b0;
            overflow_nxt  = 1'b0;
            tile_cnt_nxt  = '0;
        end else begin
            if (hs) begin
                if (out_last) begin
                    row_ptr_nxt           = 1'b0;
                    bank_full_nxt[rd_ptr] = 1'b0;
                    rd_ptr_nxt            = ~rd_ptr;
                    tile_cnt_nxt          = tile_cnt + 16'd1;
                end else begin
                    row_ptr_nxt = 1'b1;
                end
            end
            if (cap) begin
                bank_nxt[wr_ptr]      = cap_tile;
                bank_full_nxt[wr_ptr] = 1'b1;
                wr_ptr_nxt            = ~wr_ptr;
            end
            if (drop) begin
                overflow_nxt = 1'b1;
            end
        end
    end

    // State registers; output views are registered from the next-state values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank      <= '0;
            bank_full <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            row_ptr   <= 1'b0;
            overflow  <= 1'b0;
            tile_cnt  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            full      <= 1'b0;
        end else begin
            bank      <= bank_nxt;
            bank_full <= bank_full_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            row_ptr   <= row_ptr_nxt;
            overflow  <= overflow_nxt;
            tile_cnt  <= tile_cnt_nxt;
            out_valid <= bank_full_nxt[rd_ptr_nxt];
            out_last  <= (row_ptr_nxt == 1'(ROW-1));
            out_data  <= bank_nxt[rd_ptr_nxt][row_ptr_nxt];
            busy      <= |bank_full_nxt;
            full      <= &bank_full_nxt;
        end
    end

    assign out_row = row_ptr;

endmodule

// File: tb/tb_pe_array_drain.sv
// Testbench for pe_array_drain: scenario tasks plus a scoreboard of expected beats.
module tb_pe_array_drain;

    typedef logic [1:0][15:0][15:0] tile_t;
    typedef struct packed {
        logic [255:0] data;
        logic         row;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         result_valid = 1'b0;
    logic         relu_en = 1'b0;
    logic         out_ready = 1'b0;
    tile_t        result_in = '0;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_row;
    logic         out_last;
    logic         busy;
    logic         full;
    logic         overflow;
    logic [15:0]  tile_cnt;

    int    total = 0;
    int    bad = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    pe_array_drain dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .result_valid (result_valid),
        .result_in    (result_in),
        .relu_en      (relu_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_last     (out_last),
        .busy         (busy),
        .full         (full),
        .overflow     (overflow),
        .tile_cnt     (tile_cnt)
    );

    // Reference row: column c at bits [c*16+:16], negatives zeroed under ReLU
    function automatic logic [255:0] exp_row(tile_t t, int r, logic relu);
        logic [255:0] v;
        logic [15:0]  x;
        v = '0;
        for (int c = 0; c < 16; c++) begin
            x = t[r][c];
            if (relu && x[15]) x = 16'h0000;
            v[c*16 +: 16] = x;
        end
        return v;
    endfunction

    function automatic void push_tile(tile_t t, logic relu);
        beat_t b;
        for (int r = 0; r < 2; r++) begin
            b.data = exp_row(t, r, relu);
            b.row  = 1'(r);
            b.last = (r == 1);
            exp_q.push_back(b);
        end
    endfunction

    function automatic tile_t seq_tile(int base);
        tile_t t;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++)
                t[r][c] = 16'(base + r*16 + c);
        return t;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++)
                t[r][c] = 16'($urandom);
        return t;
    endfunction

    // Scoreboard: every accepted beat is compared against the oldest expected row
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && !clr && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got row=%0d data=%h, required no beat", out_row, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_row, out_last} !== {e.data, e.row, e.last}) begin
                    bad++;
                    $display("FAIL beat: got row=%0d last=%0b data=%h, required row=%0d last=%0b data=%h",
                             out_row, out_last, out_data, e.row, e.last, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tile(tile_t t, logic relu, logic expect_out);
        result_in    = t;
        relu_en      = relu;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        if (expect_out) push_tile(t, relu);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({out_valid, out_row, out_last, busy, full, overflow} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 000000", {out_valid, out_row, out_last, busy, full, overflow});
        end
        total++;
        if (tile_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL reset_tile_cnt: got %h required 0000", tile_cnt);
        end
        total++;
        if (out_data !== 256'h0) begin
            bad++;
            $display("FAIL reset_out_data: got %h required 0", out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        tile_t t;
        t = seq_tile(0);
        out_ready = 1'b1;
        pulse_tile(t, 1'b0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_row !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency: got valid=%0b row=%0b last=%0b required 1 0 0", out_valid, out_row, out_last);
        end
        total++;
        if (out_data !== 256'h000F_000E_000D_000C_000B_000A_0009_0008_0007_0006_0005_0004_0003_0002_0001_0000) begin
            bad++;
            $display("FAIL basic_row0: got %h", out_data);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: got %0b required 1", busy);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_row !== 1'b1 || out_last !== 1'b1 ||
            out_data !== 256'h001F_001E_001D_001C_001B_001A_0019_0018_0017_0016_0015_0014_0013_0012_0011_0010) begin
            bad++;
            $display("FAIL basic_row1: got valid=%0b row=%0b last=%0b data=%h", out_valid, out_row, out_last, out_data);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || tile_cnt !== 16'd1) begin
            bad++;
            $display("FAIL basic_done: got valid=%0b busy=%0b tile_cnt=%0d required 0 0 1", out_valid, busy, tile_cnt);
        end
    endtask

    task automatic test_relu();
        tile_t t;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++)
                t[r][c] = (c == 3) ? 16'h7FFF : 16'h8001;
        out_ready = 1'b1;
        pulse_tile(t, 1'b1, 1'b1);
        total++;
        if (out_data[3*16 +: 16] !== 16'h7FFF || out_data[15:0] !== 16'h0000 || out_data[255:240] !== 16'h0000) begin
            bad++;
            $display("FAIL relu_on: got col0=%h col3=%h col15=%h required 0000 7fff 0000",
                     out_data[15:0], out_data[3*16 +: 16], out_data[255:240]);
        end
        wait_drain();
        pulse_tile(t, 1'b0, 1'b1);
        total++;
        if (out_data[15:0] !== 16'h8001 || out_data[3*16 +: 16] !== 16'h7FFF) begin
            bad++;
            $display("FAIL relu_off: got col0=%h col3=%h required 8001 7fff", out_data[15:0], out_data[3*16 +: 16]);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        tile_t        t;
        logic [255:0] row0;
        t = rand_tile();
        row0 = exp_row(t, 0, 1'b0);
        out_ready = 1'b0;
        pulse_tile(t, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_row !== 1'b0 || out_last !== 1'b0 || out_data !== row0) begin
                bad++;
                $display("FAIL bp_hold%0d: got valid=%0b row=%0b last=%0b data=%h required row0 held",
                         i, out_valid, out_row, out_last, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_row !== 1'b1 || out_last !== 1'b1) begin
            bad++;
            $display("FAIL bp_advance: got row=%0b last=%0b required 1 1", out_row, out_last);
        end
        wait_drain();
    endtask

    task automatic test_pingpong();
        tile_t a;
        tile_t b;
        tile_t c;
        a = rand_tile();
        b = rand_tile();
        c = rand_tile();
        out_ready = 1'b0;
        pulse_clr();
        pulse_tile(a, 1'b0, 1'b1);
        pulse_tile(b, 1'b0, 1'b1);
        total++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL pp_full: got full=%0b overflow=%0b required 1 0", full, overflow);
        end
        pulse_tile(c, 1'b0, 1'b0);
        total++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
            bad++;
            $display("FAIL pp_overflow: got overflow=%0b full=%0b required 1 1", overflow, full);
        end
        out_ready = 1'b1;
        wait_drain();
        total++;
        if (tile_cnt !== 16'd2 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL pp_count: got tile_cnt=%0d overflow=%0b required 2 1", tile_cnt, overflow);
        end
    endtask

    task automatic test_simultaneous();
        tile_t x;
        tile_t y;
        tile_t d;
        x = rand_tile();
        y = rand_tile();
        d = seq_tile(16'h4000);
        out_ready = 1'b0;
        pulse_clr();
        pulse_tile(x, 1'b0, 1'b1);
        pulse_tile(y, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        total++;
        if (out_last !== 1'b1 || full !== 1'b1) begin
            bad++;
            $display("FAIL sim_setup: got last=%0b full=%0b required 1 1", out_last, full);
        end
        pulse_tile(d, 1'b0, 1'b1);
        total++;
        if (overflow !== 1'b0 || full !== 1'b1) begin
            bad++;
            $display("FAIL sim_capture: got overflow=%0b full=%0b required 0 1", overflow, full);
        end
        wait_drain();
        total++;
        if (tile_cnt !== 16'd3 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL sim_count: got tile_cnt=%0d overflow=%0b required 3 0", tile_cnt, overflow);
        end
    endtask

    task automatic test_clr();
        tile_t e;
        e = rand_tile();
        out_ready = 1'b0;
        pulse_tile(rand_tile(), 1'b0, 1'b0);
        pulse_tile(rand_tile(), 1'b0, 1'b0);
        pulse_tile(rand_tile(), 1'b0, 1'b0);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL clr_pre_overflow: got %0b required 1", overflow);
        end
        pulse_clr();
        total++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || tile_cnt !== 16'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clr_state: got valid=%0b overflow=%0b tile_cnt=%0d busy=%0b required 0 0 0 0",
                     out_valid, overflow, tile_cnt, busy);
        end
        out_ready = 1'b1;
        pulse_tile(e, 1'b0, 1'b1);
        wait_drain();
        total++;
        if (tile_cnt !== 16'd1) begin
            bad++;
            $display("FAIL clr_after: got tile_cnt=%0d required 1", tile_cnt);
        end
    endtask

    task automatic test_reset_mid();
        tile_t f;
        f = rand_tile();
        out_ready = 1'b0;
        pulse_tile(rand_tile(), 1'b0, 1'b1);
        pulse_tile(rand_tile(), 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || tile_cnt !== 16'd0) begin
            bad++;
            $display("FAIL midrst_state: got valid=%0b busy=%0b tile_cnt=%0d required 0 0 0", out_valid, busy, tile_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_discard: got valid=%0b required 0", out_valid);
        end
        pulse_tile(f, 1'b0, 1'b1);
        wait_drain();
        total++;
        if (tile_cnt !== 16'd1) begin
            bad++;
            $display("FAIL midrst_after: got tile_cnt=%0d required 1", tile_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_backpressure();
        test_pingpong();
        test_simultaneous();
        test_clr();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_array_drain.md
# pe_array_drain

Result drain on the output side of the 2x16 PE array. It captures one complete rounded result tile (2 rows x 16 columns x 16-bit, Q7.9) when the array signals completion. It buffers up to two tiles in a ping-pong store and streams them out one 256-bit row per beat over a valid/ready interface toward the output SRAM writer. An optional ReLU is applied at capture, and overflow is flagged when the array finishes a tile while both banks are still occupied.

## Interface
- COL, 16, PE columns per row; one 16-bit value each
- ROW, 2, PE rows per tile
- DW, 16, bits per result value
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear; empties both banks, zeroes pointers, overflow and tile_cnt
- result_valid  in  1  one-cycle pulse; result_in holds a final tile this cycle
- result_in  in  16 x [1:0][15:0]  tile from the array; [r][c] is row r, column c
- relu_en  in  1  sampled with result_valid; negative values (bit 15 = 1) are stored as 0x0000
- out_data  out  256  one row; column c at bits [c*16 +: 16]
- out_valid  out  1  out_data/out_row/out_last valid
- out_ready  in  1  downstream accepts the beat when out_valid & out_ready
- out_row  out  1  row index of the current beat
- out_last  out  1  high on the row-1 beat of a tile
- busy  out  1  at least one bank full
- full  out  1  both banks full
- overflow  out  1  sticky; a result_valid was dropped
- tile_cnt  out  16  tiles fully drained, wraps 0xFFFF->0x0000

## Operation
- Storage: bank[2][ROW][COL] of DW-bit registers, plus bank_full[1:0], wr_ptr, rd_ptr and row_ptr (1 bit each).
- Capture: on result_valid with bank[wr_ptr] free, or freed in the same cycle:
  - write all 32 values, applying ReLU per value when relu_en = 1;
  - set bank_full[wr_ptr] and toggle wr_ptr.
- Drop: on result_valid with both banks full and none freeing this cycle:
  - discard the tile and set overflow;
  - bank contents and pointers stay unchanged.
- Drain: out_valid = bank_full[rd_ptr].
  - out_data = bank[rd_ptr][row_ptr]; out_row = row_ptr; out_last = (row_ptr == ROW-1).
  - On a handshake with row_ptr = 0, row_ptr advances to 1.
  - On a handshake with out_last = 1, row_ptr returns to 0, bank_full[rd_ptr] clears, rd_ptr toggles and tile_cnt increments.
- Simultaneous capture and free of the same bank: free first, then capture. The bank ends full with the new data, with no overflow.
- clr has priority over capture and drain in the same cycle. Data registers are not cleared.
- No arithmetic other than the ReLU select. Values pass bit-exact.

## Timing
- Reset values:
  - out_valid, out_row, out_last, busy, full, overflow = 0; tile_cnt = 0;
  - wr_ptr = rd_ptr = row_ptr = 0; out_data = 0 (bank registers reset to 0).
- Latency: result_valid in cycle N into an empty drain gives out_valid = 1 with row 0 in cycle N+1.
- Throughput: with out_ready held high, one tile drains in 2 cycles. Row 1 follows row 0 in the next cycle.
- Handshake rules:
  - out_data, out_row and out_last are stable while out_valid = 1 and out_ready = 0;
  - out_valid does not drop without a handshake, except on clr or reset.
- busy and full are registered views of bank_full and update in the cycle after capture or free.
- Reset asserted mid-tile discards buffered tiles. The partially sent tile is not completed.

## Test plan
- Reset then one tile: result_in[r][c] = r*16+c, relu_en = 0, out_ready = 1 -> cycle N+1 row 0 = 0x000F..0x0000 (col c at bits [c*16+:16]) with out_last = 0; cycle N+2 row 1 = 0x001F..0x0010 with out_last = 1; tile_cnt = 1.
- ReLU: tile with all values 0x8001 plus col 3 = 0x7FFF, relu_en = 1 -> each row has 0x7FFF at col 3 and 0x0000 elsewhere. Same tile with relu_en = 0 -> values unchanged.
- Backpressure: out_ready = 0 for 5 cycles after out_valid -> row 0 beat is held stable; row_ptr advances only after out_ready = 1.
- Ping-pong and overflow: three result_valid pulses A, B, C with out_ready = 0 -> full = 1; C is dropped and overflow = 1. Then out_ready = 1 -> A rows then B rows are output, tile_cnt = 2.
- Simultaneous free and capture: both banks full, out_last handshake in the same cycle as result_valid D -> no overflow; D is output after the remaining tile.
- clr with a buffered tile and overflow set -> next cycle out_valid = 0, overflow = 0, tile_cnt = 0. A new tile then drains normally.
